lifo_arbiter: RTL and testbench
===============================

# lifo_arbiter

Two-requester, round-robin arbitrated LIFO stack for the storage subsystem. Owns a DEPTH x DATA_W stack memory and a fill counter, and sequences push and pop transactions from two independent requesters through a three-state controller. Overflow and underflow are rejected and flagged. Memory contents are never corrupted by an illegal request.

## Interface
- DATA_W, 8, data width
- DEPTH, 256, number of stack entries
- CNT_W, 9, counter width; must satisfy 2^CNT_W > DEPTH

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req0 / req1  in  1  transaction request, requester 0 / 1
- op0 / op1  in  1  1 = push, 0 = pop
- wdata0 / wdata1  in  DATA_W  push data
- gnt0 / gnt1  out  1  one-cycle completion pulse to the served requester
- rdata  out  DATA_W  popped data
- rvalid  out  1  one-cycle pulse; rdata valid
- err  out  1  rejected transaction (push when full, pop when empty)
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  CNT_W  current number of entries

## Operation
- States: ARB, EXEC, DONE. Reset state is ARB.
- ARB:
  - If no req, stay in ARB.
  - Otherwise latch the winner id, its op and its wdata, then go to EXEC.
- EXEC: perform the operation, then go to DONE.
  - Push, not full: mem[count] <= wdata; count + 1.
  - Pop, not empty: rdata <= mem[count-1]; count - 1.
  - Push when full, or pop when empty: no memory write, count unchanged, rdata unchanged, err set.
- DONE:
  - gnt of the winner is high.
  - rvalid is high only for a successful pop.
  - err is high for a rejected transaction.
  - Next state is ARB.
- Arbitration: round robin on last_served, which resets to 1 so requester 0 wins first.
  - When both requests are high, grant the requester that is not last_served.
  - A single request always wins.
  - last_served updates when leaving ARB.
- Requester rules:
  - Hold req, op and wdata stable from assertion until gnt is seen.
  - Deassert req in the cycle after gnt, unless issuing a new request.
  - A req still high in ARB is a new transaction.
- Arithmetic:
  - count never wraps; saturation is guaranteed by the rejection rule.
  - The pointer is count itself; no separate pointer register.
- Reset (also mid-transaction):
  - state ARB, count 0, empty 1, full 0.
  - gnt0/gnt1/rvalid/err 0, rdata 0, last_served 1.
  - Memory is not cleared; any in-flight transaction is abandoned without gnt.

## Timing
- Request sampled at edge E0 (state ARB): EXEC after E0.
- Memory and count update at E1: DONE after E1.
  - gnt, rvalid, rdata, err, full, empty and count are all registered and valid during DONE.
- Back to ARB after E2.
- Throughput: one transaction per 3 cycles.
- Latency: req-to-gnt is 2 cycles, with no contention.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- LIFO_ARB_STICKY_ERR_EN:
  - Defined: err is set by any rejected transaction and stays 1 until rst.
  - Undefined: err is a one-cycle pulse aligned with gnt in DONE.
- Arbitration, memory and count behaviour are identical in both builds.

## Test plan
- Reset, then requester 0 pushes 0x11, 0x22, 0x33, then pops three times: rdata 0x33, 0x22, 0x11, each with rvalid; count goes 3 -> 0; empty=1 at end.
- Pop on empty stack: gnt0 pulses, rvalid=0, err=1, count stays 0, rdata unchanged.
- Fill to DEPTH=256 with pushes, then one more push of 0xAA: full=1, err=1, count=256; next pop returns the 256th value, not 0xAA.
- req0 and req1 both held high with pushes 0xA0 and 0xB0: grants in order gnt0, gnt1, gnt0, gnt1; first-pushed sequence is 0xA0, 0xB0.
- Assert rst during EXEC of a push: no gnt; after reset count=0, empty=1, all outputs 0; the next request is served by requester 0.
- With LIFO_ARB_STICKY_ERR_EN, underflow then a valid push: err stays 1 until rst. Without the macro: err is a single-cycle pulse.

Source files
------------

// File: rtl/lifo_arbiter_if.sv
// lifo_arbiter_if: requester/status bundle for lifo_arbiter.
// Signal prefixes are from the arbiter's point of view:
//   i_req0/1, i_op0/1 (1=push, 0=pop), i_wdata0/1 : requester inputs
//   o_gnt0/1, o_rdata, o_rvalid, o_err            : completion / pop result
//   o_full, o_empty, o_count                      : stack status
// Modports: slave = arbiter side, master = requester side.
interface lifo_arbiter_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 9
) ();

  logic              i_req0;
  logic              i_req1;
  logic              i_op0;
  logic              i_op1;
  logic [DATA_W-1:0] i_wdata0;
  logic [DATA_W-1:0] i_wdata1;
  logic              o_gnt0;
  logic              o_gnt1;
  logic [DATA_W-1:0] o_rdata;
  logic              o_rvalid;
  logic              o_err;
  logic              o_full;
  logic              o_empty;
  logic [CNT_W-1:0]  o_count;

  modport slave (
    input  i_req0, i_req1, i_op0, i_op1, i_wdata0, i_wdata1,
    output o_gnt0, o_gnt1, o_rdata, o_rvalid, o_err, o_full, o_empty, o_count
  );

  modport master (
    output i_req0, i_req1, i_op0, i_op1, i_wdata0, i_wdata1,
    input  o_gnt0, o_gnt1, o_rdata, o_rvalid, o_err, o_full, o_empty, o_count
  );

endinterface

// File: rtl/lifo_arbiter.sv
// lifo_arbiter: two-requester round-robin arbitrated LIFO stack.
// A three-state controller (ARB -> EXEC -> DONE) serves one push or pop per
// three cycles. Push when full / pop when empty is rejected with err and
// leaves memory, count and rdata untouched.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : lifo_arbiter_if.slave (requests, grants, pop data, status)
// Build option:
//   LIFO_ARB_STICKY_ERR_EN : when defined, err stays high after any rejected
//                            transaction until rst; otherwise err is a
//                            one-cycle pulse aligned with gnt.
module lifo_arbiter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned CNT_W  = 9
) (
  input  logic           clk,
  input  logic           rst,
  lifo_arbiter_if.slave  bus
);

  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_ARB  = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_last;   // id of last served requester
  logic              r_id;     // latched winner
  logic              r_op;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_count;
  logic              r_full;
  logic              r_empty;
  logic [DATA_W-1:0] r_rdata;
  logic              r_rvalid;
  logic              r_err;
  logic              r_gnt0;
  logic              r_gnt1;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic w_any;
  logic w_win;
  logic w_push_ok;

  // Round robin: on contention the requester not served last wins.
  assign w_any = bus.i_req0 | bus.i_req1;
  assign w_win = (bus.i_req0 & bus.i_req1) ? ~r_last : bus.i_req1;

  assign w_push_ok = (r_state == ST_EXEC) && r_op && !r_full;

  // Stack storage; never reset, and an abandoned push is not written.
  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) begin
      r_mem[ADDR_W'(r_count)] <= r_wdata;
    end
  end

  // Controller, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_ARB;
      r_last   <= 1'b1;
      r_id     <= 1'b0;
      r_op     <= 1'b0;
      r_wdata  <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
    end else begin
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_rvalid <= 1'b0;
`ifndef LIFO_ARB_STICKY_ERR_EN
      r_err    <= 1'b0;
`endif
      case (r_state)
        ST_ARB: begin
          if (w_any) begin
            r_id    <= w_win;
            r_last  <= w_win;
            r_op    <= w_win ? bus.i_op1 : bus.i_op0;
            r_wdata <= w_win ? bus.i_wdata1 : bus.i_wdata0;
            r_state <= ST_EXEC;
          end
        end

        ST_EXEC: begin
          r_gnt0  <= ~r_id;
          r_gnt1  <= r_id;
          r_state <= ST_DONE;
          if (r_op) begin
            if (r_full) begin
              r_err <= 1'b1;
            end else begin
              r_count <= r_count + ONE_CNT;
              r_full  <= (r_count + ONE_CNT) == FULL_CNT;
              r_empty <= 1'b0;
            end
          end else begin
            if (r_empty) begin
              r_err <= 1'b1;
            end else begin
              r_rdata  <= r_mem[ADDR_W'(r_count - ONE_CNT)];
              r_rvalid <= 1'b1;
              r_count  <= r_count - ONE_CNT;
              r_empty  <= r_count == ONE_CNT;
              r_full   <= 1'b0;
            end
          end
        end

        ST_DONE: begin
          r_state <= ST_ARB;
        end

        default: begin
          r_state <= ST_ARB;
        end
      endcase
    end
  end

  assign bus.o_gnt0   = r_gnt0;
  assign bus.o_gnt1   = r_gnt1;
  assign bus.o_rdata  = r_rdata;
  assign bus.o_rvalid = r_rvalid;
  assign bus.o_err    = r_err;
  assign bus.o_full   = r_full;
  assign bus.o_empty  = r_empty;
  assign bus.o_count  = r_count;

endmodule

// File: tb/tb_lifo_arbiter.sv
// tb_lifo_arbiter: scenario tasks driving lifo_arbiter, with expected values
// taken from a queue-based stack model.
module tb_lifo_arbiter;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned CNT_W  = 9;
`ifdef LIFO_ARB_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lifo_arbiter_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  lifo_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model
  logic [DATA_W-1:0] stk [$];
  logic [DATA_W-1:0] m_rdata;
  bit                m_sticky;
  logic              exp_rvalid, exp_err, exp_full, exp_empty;
  logic [DATA_W-1:0] exp_rdata;
  logic [CNT_W-1:0]  exp_count;

  // observed at the grant
  logic              obs_gnt0, obs_gnt1, obs_rvalid, obs_err, obs_full, obs_empty;
  logic [DATA_W-1:0] obs_rdata;
  logic [CNT_W-1:0]  obs_count;
  int                obs_lat;
  bit                obs_timeout;

  task automatic model_reset();
    stk.delete();
    m_rdata  = '0;
    m_sticky = 1'b0;
  endtask

  task automatic model_txn(input bit op, input logic [DATA_W-1:0] d);
    bit rej;
    exp_rvalid = 1'b0;
    if (op) begin
      rej = (stk.size() == DEPTH);
      if (!rej) stk.push_back(d);
    end else begin
      rej = (stk.size() == 0);
      if (!rej) begin
        m_rdata    = stk.pop_back();
        exp_rvalid = 1'b1;
      end
    end
    if (rej) m_sticky = 1'b1;
    exp_err   = STICKY ? m_sticky : rej;
    exp_rdata = m_rdata;
    exp_count = CNT_W'(stk.size());
    exp_full  = (stk.size() == DEPTH);
    exp_empty = (stk.size() == 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.i_req0 = 1'b0;
    bus.i_req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic capture();
    obs_gnt0   = bus.o_gnt0;
    obs_gnt1   = bus.o_gnt1;
    obs_rvalid = bus.o_rvalid;
    obs_err    = bus.o_err;
    obs_rdata  = bus.o_rdata;
    obs_count  = bus.o_count;
    obs_full   = bus.o_full;
    obs_empty  = bus.o_empty;
  endtask

  // Issue one request and wait (bounded) for its grant.
  task automatic run_txn(input bit id, input bit op, input logic [DATA_W-1:0] d);
    @(negedge clk);
    if (id) begin
      bus.i_req1 = 1'b1; bus.i_op1 = op; bus.i_wdata1 = d;
    end else begin
      bus.i_req0 = 1'b1; bus.i_op0 = op; bus.i_wdata0 = d;
    end
    obs_lat = 0;
    obs_timeout = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.o_gnt0 || bus.o_gnt1) begin
        obs_lat = c;
        obs_timeout = 1'b0;
        break;
      end
    end
    capture();
    bus.i_req0 = 1'b0;
    bus.i_req1 = 1'b0;
    if (obs_timeout) begin
      checks++; errors++;
      $display("FAIL txn_timeout: no grant within 12 cycles (id %0d op %0d)", id, op);
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (bus.o_count !== '0 || bus.o_empty !== 1'b1 || bus.o_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: count %0d empty %b full %b, want 0 1 0",
               bus.o_count, bus.o_empty, bus.o_full);
    end
    checks++;
    if ({bus.o_gnt0, bus.o_gnt1, bus.o_rvalid, bus.o_err} !== 4'b0000 || bus.o_rdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: gnt0 %b gnt1 %b rvalid %b err %b rdata %h, want all 0",
               bus.o_gnt0, bus.o_gnt1, bus.o_rvalid, bus.o_err, bus.o_rdata);
    end
  endtask

  task automatic test_push_pop();
    logic [DATA_W-1:0] vals [3];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run_txn(1'b0, 1'b1, vals[i]);
      model_txn(1'b1, vals[i]);
      checks++;
      if (obs_gnt0 !== 1'b1 || obs_lat != 2) begin
        errors++;
        $display("FAIL push_grant: gnt0 %b latency %0d, want 1 2", obs_gnt0, obs_lat);
      end
      checks++;
      if (obs_count !== exp_count) begin
        errors++;
        $display("FAIL push_count: got %0d want %0d", obs_count, exp_count);
      end
    end
    for (int i = 0; i < 3; i++) begin
      run_txn(1'b0, 1'b0, 8'h00);
      model_txn(1'b0, 8'h00);
      checks++;
      if (obs_rdata !== exp_rdata || obs_rvalid !== 1'b1 || obs_count !== exp_count) begin
        errors++;
        $display("FAIL pop_data: rdata %h rvalid %b count %0d, want %h 1 %0d",
                 obs_rdata, obs_rvalid, obs_count, exp_rdata, exp_count);
      end
    end
    checks++;
    if (obs_empty !== 1'b1 || obs_rdata !== 8'h11) begin
      errors++;
      $display("FAIL pop_final: empty %b rdata %h, want 1 11", obs_empty, obs_rdata);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    run_txn(1'b0, 1'b1, 8'h5C); model_txn(1'b1, 8'h5C);
    run_txn(1'b0, 1'b0, 8'h00); model_txn(1'b0, 8'h00);
    run_txn(1'b0, 1'b0, 8'h00); model_txn(1'b0, 8'h00);
    checks++;
    if (obs_gnt0 !== 1'b1 || obs_rvalid !== 1'b0 || obs_err !== 1'b1) begin
      errors++;
      $display("FAIL underflow_flags: gnt0 %b rvalid %b err %b, want 1 0 1",
               obs_gnt0, obs_rvalid, obs_err);
    end
    checks++;
    if (obs_count !== exp_count || obs_rdata !== 8'h5C || obs_empty !== 1'b1) begin
      errors++;
      $display("FAIL underflow_state: count %0d rdata %h empty %b, want %0d 5c 1",
               obs_count, obs_rdata, obs_empty, exp_count);
    end
  endtask

  task automatic test_overflow();
    logic [DATA_W-1:0] d;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      d = DATA_W'($urandom);
      run_txn(1'b0, 1'b1, d);
      model_txn(1'b1, d);
      if (i == DEPTH - 2) begin
        checks++;
        if (obs_full !== 1'b0 || obs_count !== exp_count) begin
          errors++;
          $display("FAIL near_full: full %b count %0d, want 0 %0d", obs_full, obs_count, exp_count);
        end
      end
    end
    run_txn(1'b0, 1'b1, 8'hAA);
    model_txn(1'b1, 8'hAA);
    checks++;
    if (obs_full !== 1'b1 || obs_err !== 1'b1 || obs_count !== CNT_W'(DEPTH) || obs_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL overflow: full %b err %b count %0d rvalid %b, want 1 1 %0d 0",
               obs_full, obs_err, obs_count, obs_rvalid, DEPTH);
    end
    run_txn(1'b1, 1'b0, 8'h00);
    model_txn(1'b0, 8'h00);
    checks++;
    if (obs_rdata !== exp_rdata || obs_gnt1 !== 1'b1 || obs_count !== exp_count || obs_full !== 1'b0) begin
      errors++;
      $display("FAIL overflow_pop: rdata %h gnt1 %b count %0d full %b, want %h 1 %0d 0",
               obs_rdata, obs_gnt1, obs_count, obs_full, exp_rdata, exp_count);
    end
  endtask

  task automatic test_back_to_back();
    int gid [4];
    int gcyc [4];
    int n;
    do_reset();
    @(negedge clk);
    bus.i_req0 = 1'b1; bus.i_op0 = 1'b1; bus.i_wdata0 = 8'hA0;
    bus.i_req1 = 1'b1; bus.i_op1 = 1'b1; bus.i_wdata1 = 8'hB0;
    n = 0;
    for (int c = 1; c <= 40 && n < 4; c++) begin
      @(negedge clk);
      if (bus.o_gnt0 || bus.o_gnt1) begin
        gid[n]  = bus.o_gnt1 ? 1 : 0;
        gcyc[n] = c;
        model_txn(1'b1, bus.o_gnt1 ? 8'hB0 : 8'hA0);
        n++;
      end
    end
    capture();
    bus.i_req0 = 1'b0;
    bus.i_req1 = 1'b0;
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL rr_grants: got %0d grants, want 4", n);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (gid[i] != (i % 2) || (i > 0 && gcyc[i] - gcyc[i-1] != 3)) begin
          errors++;
          $display("FAIL rr_order: grant %0d to %0d after %0d cycles, want %0d after 3",
                   i, gid[i], (i > 0) ? gcyc[i] - gcyc[i-1] : gcyc[i], i % 2);
        end
      end
    end
    checks++;
    if (obs_count !== CNT_W'(4)) begin
      errors++;
      $display("FAIL rr_count: got %0d want 4", obs_count);
    end
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b0, 1'b0, 8'h00);
      model_txn(1'b0, 8'h00);
      checks++;
      if (obs_rdata !== exp_rdata || obs_rvalid !== 1'b1) begin
        errors++;
        $display("FAIL rr_pop: rdata %h rvalid %b, want %h 1", obs_rdata, obs_rvalid, exp_rdata);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit got;
    do_reset();
    run_txn(1'b0, 1'b1, 8'h77);
    run_txn(1'b0, 1'b1, 8'h66);
    run_txn(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    bus.i_req0 = 1'b1; bus.i_op0 = 1'b1; bus.i_wdata0 = 8'h99;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.o_gnt0 !== 1'b0 || bus.o_gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_gnt: gnt0 %b gnt1 %b, want 0 0", bus.o_gnt0, bus.o_gnt1);
    end
    checks++;
    if (bus.o_count !== '0 || bus.o_empty !== 1'b1 || bus.o_full !== 1'b0 ||
        bus.o_rdata !== '0 || bus.o_rvalid !== 1'b0 || bus.o_err !== 1'b0) begin
      errors++;
      $display("FAIL midreset_state: count %0d empty %b full %b rdata %h rvalid %b err %b, want 0 1 0 00 0 0",
               bus.o_count, bus.o_empty, bus.o_full, bus.o_rdata, bus.o_rvalid, bus.o_err);
    end
    bus.i_req0 = 1'b0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    bus.i_req0 = 1'b1; bus.i_op0 = 1'b1; bus.i_wdata0 = 8'h12;
    bus.i_req1 = 1'b1; bus.i_op1 = 1'b1; bus.i_wdata1 = 8'h34;
    got = 1'b0;
    for (int c = 1; c <= 12 && !got; c++) begin
      @(negedge clk);
      if (bus.o_gnt0 || bus.o_gnt1) got = 1'b1;
    end
    capture();
    bus.i_req0 = 1'b0;
    bus.i_req1 = 1'b0;
    checks++;
    if (!got || obs_gnt0 !== 1'b1 || obs_gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_first: gnt0 %b gnt1 %b, want 1 0", obs_gnt0, obs_gnt1);
    end
    model_txn(1'b1, 8'h12);
    run_txn(1'b1, 1'b0, 8'h00);
    model_txn(1'b0, 8'h00);
    checks++;
    if (obs_rdata !== exp_rdata || obs_count !== exp_count) begin
      errors++;
      $display("FAIL midreset_pop: rdata %h count %0d, want %h %0d",
               obs_rdata, obs_count, exp_rdata, exp_count);
    end
  endtask

  task automatic test_err_mode();
    do_reset();
    run_txn(1'b0, 1'b0, 8'h00);
    model_txn(1'b0, 8'h00);
    checks++;
    if (obs_err !== 1'b1) begin
      errors++;
      $display("FAIL err_underflow: got %b want 1", obs_err);
    end
    @(negedge clk);
    checks++;
    if (bus.o_err !== STICKY) begin
      errors++;
      $display("FAIL err_idle: got %b want %b", bus.o_err, STICKY);
    end
    run_txn(1'b1, 1'b1, 8'h42);
    model_txn(1'b1, 8'h42);
    checks++;
    if (obs_err !== exp_err || obs_gnt1 !== 1'b1 || obs_count !== exp_count) begin
      errors++;
      $display("FAIL err_after_push: err %b gnt1 %b count %0d, want %b 1 %0d",
               obs_err, obs_gnt1, obs_count, exp_err, exp_count);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (bus.o_err !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared: got %b want 0", bus.o_err);
    end
  endtask

  task automatic test_random();
    bit                id, op;
    logic [DATA_W-1:0] d;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      id = 1'($urandom_range(0, 1));
      op = ($urandom_range(0, 99) < ((i < 150) ? 65 : 35));
      d  = DATA_W'($urandom);
      run_txn(id, op, d);
      model_txn(op, d);
      checks++;
      if (obs_gnt0 !== ~id || obs_gnt1 !== id) begin
        errors++;
        $display("FAIL rand_gnt[%0d]: gnt0 %b gnt1 %b, requester %0d", i, obs_gnt0, obs_gnt1, id);
      end
      checks++;
      if (obs_rvalid !== exp_rvalid || obs_err !== exp_err || obs_rdata !== exp_rdata) begin
        errors++;
        $display("FAIL rand_result[%0d]: rvalid %b err %b rdata %h, want %b %b %h",
                 i, obs_rvalid, obs_err, obs_rdata, exp_rvalid, exp_err, exp_rdata);
      end
      checks++;
      if (obs_count !== exp_count || obs_full !== exp_full || obs_empty !== exp_empty) begin
        errors++;
        $display("FAIL rand_status[%0d]: count %0d full %b empty %b, want %0d %b %b",
                 i, obs_count, obs_full, obs_empty, exp_count, exp_full, exp_empty);
      end
    end
  endtask

  initial begin
    bus.i_req0 = 1'b0; bus.i_req1 = 1'b0;
    bus.i_op0 = 1'b0;  bus.i_op1 = 1'b0;
    bus.i_wdata0 = '0; bus.i_wdata1 = '0;
    model_reset();
    test_reset();
    test_push_pop();
    test_underflow();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_err_mode();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
